// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: bus widths, op codes, FSM states.
// Helpers classify memory ops by access size and direction.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP = 8'h20;
  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_byte(input logic [AluOpBus-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_SB_OP);
  endfunction

  function automatic logic is_half(input logic [AluOpBus-1:0] op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic is_word(input logic [AluOpBus-1:0] op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
    return is_byte(op) || is_half(op) || is_word(op);
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Picks the addressed byte/half lane of big-endian read data and sign/zero extends it.
// Purely combinational; non-load ops yield zero.
module mem_lane_ext
  import mem_lsu_pkg::*;
(
  input  logic [RegBus-1:0]   rdata,
  input  logic [1:0]          offset,
  input  logic [AluOpBus-1:0] op,
  output logic [RegBus-1:0]   result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'b00:   byte_lane = rdata[31:24];
      2'b01:   byte_lane = rdata[23:16];
      2'b10:   byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = offset[1] ? rdata[15:0] : rdata[31:16];

    result = ZeroWord;
    case (op)
      EXE_LB_OP:  result = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: result = {24'd0, byte_lane};
      EXE_LH_OP:  result = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: result = {16'd0, half_lane};
      EXE_LW_OP:  result = rdata;
      default:    result = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: ALU pass-through, or one registered req/ack bus transaction per load/store.
// Latency: 0 cycles for non-memory ops, ack cycle + 2 for memory ops; stallReq holds the pipe until DONE.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with a one-cycle alignErr_o pulse.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluOp_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [RegBus-1:0]     storeData_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stallReq,
  output logic [31:0]           bus_addr_o,
  output logic [31:0]           bus_wdata_o,
  output logic [3:0]            bus_sel_o,
  output logic                  bus_we_o,
  output logic                  bus_req_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_rdata_i,
  output logic                  alignErr_o
);

  lsu_state_t            state_q, state_d;
  logic [AluOpBus-1:0]   op_q;
  logic [RegAddrBus-1:0] wd_q;
  logic                  wreg_q;
  logic [1:0]            offset_q;
  logic [RegBus-1:0]     load_q;
  logic [RegBus-1:0]     ext_result;
  logic                  mem_op, misaligned, start;
  logic [3:0]            sel_d;
  logic [31:0]           lane_wdata;

  assign mem_op = is_mem_op(aluOp_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half(aluOp_i) && wdata_i[0]) ||
                      (is_word(aluOp_i) && (wdata_i[1:0] != 2'b00));
  assign alignErr_o = !rst && (state_q == IDLE) && mem_op && misaligned;
`else
  assign misaligned = 1'b0;
  assign alignErr_o = 1'b0;
`endif

  assign start = (state_q == IDLE) && mem_op && !misaligned;

  // Lane enables and replicated store data; size decides which address bits matter.
  always_comb begin
    sel_d      = 4'b1111;
    lane_wdata = storeData_i;
    if (is_byte(aluOp_i)) begin
      sel_d      = 4'b1000 >> wdata_i[1:0];
      lane_wdata = {4{storeData_i[7:0]}};
    end else if (is_half(aluOp_i)) begin
      sel_d      = wdata_i[1] ? 4'b0011 : 4'b1100;
      lane_wdata = {2{storeData_i[15:0]}};
    end
  end

  mem_lane_ext u_lane_ext (
    .rdata  (bus_rdata_i),
    .offset (offset_q),
    .op     (op_q),
    .result (ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_sel_o   <= '0;
      bus_we_o    <= 1'b0;
      bus_req_o   <= 1'b0;
      op_q        <= EXE_NOP_OP;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      offset_q    <= 2'b00;
      load_q      <= ZeroWord;
    end else begin
      state_q <= state_d;
      if (start) begin
        bus_addr_o  <= {wdata_i[31:2], 2'b00};
        bus_wdata_o <= lane_wdata;
        bus_sel_o   <= sel_d;
        bus_we_o    <= is_store(aluOp_i);
        bus_req_o   <= 1'b1;
        op_q        <= aluOp_i;
        wd_q        <= wd_i;
        wreg_q      <= wreg_i;
        offset_q    <= wdata_i[1:0];
      end else if ((state_q == BUSY) && bus_ack_i) begin
        bus_req_o <= 1'b0;
        bus_we_o  <= 1'b0;
        load_q    <= ext_result;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wd_o     = wd_i;
    wreg_o   = wreg_i;
    wdata_o  = wdata_i;
    stallReq = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          wreg_o  = WriteDisable;
          wdata_o = ZeroWord;
          if (start) begin
            stallReq = 1'b1;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stallReq = 1'b1;
        wd_o     = wd_q;
        wreg_o   = WriteDisable;
        wdata_o  = ZeroWord;
        if (bus_ack_i) state_d = DONE;
      end
      DONE: begin
        wd_o    = wd_q;
        wreg_o  = is_store(op_q) ? WriteDisable : wreg_q;
        wdata_o = is_store(op_q) ? ZeroWord : load_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      wd_o     = '0;
      wreg_o   = 1'b0;
      wdata_o  = ZeroWord;
      stallReq = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: responsive bus slave, expectations queued at stimulus time, checked at DONE.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalignment rejection path.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [AluOpBus-1:0]   aluOp_i;
  logic [RegAddrBus-1:0] wd_i;
  logic                  wreg_i;
  logic [RegBus-1:0]     wdata_i, storeData_i;
  logic [RegAddrBus-1:0] wd_o;
  logic                  wreg_o, stallReq;
  logic [RegBus-1:0]     wdata_o;
  logic [31:0]           bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]            bus_sel_o;
  logic                  bus_we_o, bus_req_o, bus_ack_i, alignErr_o;

  mem_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .aluOp_i     (aluOp_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .storeData_i (storeData_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallReq    (stallReq),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_sel_o   (bus_sel_o),
    .bus_we_o    (bus_we_o),
    .bus_req_o   (bus_req_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .alignErr_o  (alignErr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic        we;
    logic [31:0] wdata;
    logic        wreg;
    int          stall;
  } exp_t;
  exp_t exp_q[$];

  // Observations of the last transaction driven by run_mem.
  logic [31:0] o_addr, o_bwdata, o_wdata;
  logic [3:0]  o_sel;
  logic [4:0]  o_wd;
  logic        o_we, o_wreg, o_done, o_align, o_unstable, o_req_at_done;
  int          o_stall, o_req, o_first_req;

  // Drives one memory op (caller is just after a posedge) and acts as bus slave,
  // acking on the ack_wait-th cycle of the request. Returns just after the posedge
  // that ends the DONE cycle with a NOP on the inputs.
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_wait);
    aluOp_i = op; wdata_i = addr; storeData_i = sdata; wd_i = 5'd9; wreg_i = 1'b1;
    o_stall = 0; o_req = 0; o_done = 1'b0; o_align = 1'b0; o_unstable = 1'b0;
    o_first_req = -1; o_req_at_done = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      bus_ack_i = 1'b0;
      if (c == 1) wd_i = 5'd0;
      if (alignErr_o) o_align = 1'b1;
      if (stallReq) o_stall++;
      else if (o_stall > 0) begin
        o_wdata = wdata_o; o_wreg = wreg_o; o_wd = wd_o; o_req_at_done = bus_req_o;
        o_done = 1'b1;
        break;
      end
      if (bus_req_o) begin
        if (o_req == 0) begin
          o_first_req = c; o_addr = bus_addr_o; o_sel = bus_sel_o;
          o_bwdata = bus_wdata_o; o_we = bus_we_o;
        end else if ({bus_addr_o, bus_sel_o, bus_wdata_o, bus_we_o} !== {o_addr, o_sel, o_bwdata, o_we})
          o_unstable = 1'b1;
        o_req++;
        if (o_req == ack_wait) begin bus_ack_i = 1'b1; bus_rdata_i = rdata; end
      end
    end
    @(posedge clk); #1;
    aluOp_i = EXE_NOP_OP; wreg_i = 1'b0; wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_DEAD;
  endtask

  task automatic test_reset;
    rst = 1'b1; aluOp_i = EXE_ADD_OP; wdata_i = 32'h0000_1234; wreg_i = 1'b1; wd_i = 5'd3;
    storeData_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    checks++;
    if ({wd_o, wreg_o, wdata_o, stallReq} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs: got wd=%0d wreg=%b wdata=%h stall=%b, want all 0", wd_o, wreg_o, wdata_o, stallReq);
    end
    checks++;
    if ({bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o, bus_req_o, alignErr_o} !== 71'd0) begin
      errors++; $display("FAIL reset_bus: got addr=%h wdata=%h sel=%b we=%b req=%b aerr=%b, want all 0",
                         bus_addr_o, bus_wdata_o, bus_sel_o, bus_we_o, bus_req_o, alignErr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; aluOp_i = EXE_NOP_OP; wreg_i = 1'b0;
  endtask

  task automatic test_passthrough;
    aluOp_i = EXE_ADD_OP; wdata_i = 32'h0000_1234; wreg_i = 1'b1; wd_i = 5'd4; bus_ack_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({wdata_o, wreg_o, wd_o, stallReq, bus_req_o} !== {32'h0000_1234, 1'b1, 5'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL passthrough_add: got wdata=%h wreg=%b wd=%0d stall=%b req=%b, want 00001234 1 4 0 0",
                         wdata_o, wreg_o, wd_o, stallReq, bus_req_o);
    end
    @(posedge clk); #1;
    bus_ack_i = 1'b0; wdata_i = 32'h0000_5678; wreg_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({wdata_o, wreg_o, stallReq, bus_req_o} !== {32'h0000_5678, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL passthrough_stray_ack: got wdata=%h wreg=%b stall=%b req=%b, want 00005678 0 0 0",
                         wdata_o, wreg_o, stallReq, bus_req_o);
    end
    @(posedge clk); #1;
    aluOp_i = EXE_NOP_OP;
  endtask

  task automatic test_load;
    logic [7:0]  ops[6]   = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LB_OP, EXE_LW_OP};
    logic [31:0] addrs[6] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h001, 32'h208};
    logic [31:0] rds[6]   = '{32'h1122_3380, 32'h1122_3380, 32'h8001_7FFF, 32'h8001_F234, 32'h12A4_5678, 32'h89AB_CDEF};
    logic [31:0] res[6]   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F234, 32'hFFFF_FFA4, 32'h89AB_CDEF};
    logic [3:0]  sels[6]  = '{4'b0001, 4'b0001, 4'b1100, 4'b0011, 4'b0100, 4'b1111};
    int          acks[6]  = '{2, 1, 1, 3, 1, 2};
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e = '{addr: {addrs[i][31:2], 2'b00}, sel: sels[i], bwdata: 32'h0, we: 1'b0,
            wdata: res[i], wreg: 1'b1, stall: acks[i] + 1};
      exp_q.push_back(e);
      run_mem(ops[i], addrs[i], 32'h0, rds[i], acks[i]);
      e = exp_q.pop_front();
      checks++;
      if (!o_done) begin errors++; $display("FAIL load%0d_timeout: DONE never seen", i); end
      checks++;
      if ({o_addr, o_sel, o_we} !== {e.addr, e.sel, e.we}) begin
        errors++; $display("FAIL load%0d_bus: got addr=%h sel=%b we=%b, want %h %b %b", i, o_addr, o_sel, o_we, e.addr, e.sel, e.we);
      end
      checks++;
      if ({o_wdata, o_wreg, o_wd} !== {e.wdata, e.wreg, 5'd9}) begin
        errors++; $display("FAIL load%0d_result: got wdata=%h wreg=%b wd=%0d, want %h %b 9", i, o_wdata, o_wreg, o_wd, e.wdata, e.wreg);
      end
      checks++;
      if (o_stall != e.stall || o_first_req != 1 || o_unstable || o_req_at_done) begin
        errors++; $display("FAIL load%0d_timing: got stall=%0d first_req=%0d unstable=%b req_at_done=%b, want %0d 1 0 0",
                           i, o_stall, o_first_req, o_unstable, o_req_at_done, e.stall);
      end
    end
  endtask

  task automatic test_store;
    logic [7:0]  ops[4]   = '{EXE_SH_OP, EXE_SB_OP, EXE_SB_OP, EXE_SW_OP};
    logic [31:0] addrs[4] = '{32'h202, 32'h201, 32'h203, 32'h404};
    logic [31:0] sds[4]   = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_56A5, 32'h0BAD_F00D};
    logic [31:0] bws[4]   = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hA5A5_A5A5, 32'h0BAD_F00D};
    logic [3:0]  sels[4]  = '{4'b0011, 4'b0100, 4'b0001, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e = '{addr: {addrs[i][31:2], 2'b00}, sel: sels[i], bwdata: bws[i], we: 1'b1,
            wdata: 32'h0, wreg: 1'b0, stall: 3};
      exp_q.push_back(e);
      run_mem(ops[i], addrs[i], sds[i], 32'hFFFF_FFFF, 2);
      e = exp_q.pop_front();
      checks++;
      if (!o_done) begin errors++; $display("FAIL store%0d_timeout: DONE never seen", i); end
      checks++;
      if ({o_addr, o_sel, o_bwdata, o_we} !== {e.addr, e.sel, e.bwdata, e.we}) begin
        errors++; $display("FAIL store%0d_bus: got addr=%h sel=%b wdata=%h we=%b, want %h %b %h %b",
                           i, o_addr, o_sel, o_bwdata, o_we, e.addr, e.sel, e.bwdata, e.we);
      end
      checks++;
      if ({o_wdata, o_wreg, o_stall} !== {e.wdata, e.wreg, e.stall}) begin
        errors++; $display("FAIL store%0d_done: got wdata=%h wreg=%b stall=%0d, want %h %b %0d",
                           i, o_wdata, o_wreg, o_stall, e.wdata, e.wreg, e.stall);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] first_addr;
    exp_q.push_back('{addr: 32'h400, sel: 4'b1111, bwdata: 32'h0, we: 1'b0, wdata: 32'hCAFE_F00D, wreg: 1'b1, stall: 2});
    exp_q.push_back('{addr: 32'h404, sel: 4'b1111, bwdata: 32'h0BAD_F00D, we: 1'b1, wdata: 32'h0, wreg: 1'b0, stall: 2});
    run_mem(EXE_LW_OP, 32'h400, 32'h0, 32'hCAFE_F00D, 1);
    begin
      exp_t e;
      e = exp_q.pop_front();
      first_addr = o_addr;
      checks++;
      if (!o_done || {o_addr, o_we, o_wdata, o_wreg, o_stall, o_req_at_done} !== {e.addr, e.we, e.wdata, e.wreg, e.stall, 1'b0}) begin
        errors++; $display("FAIL b2b_lw: got done=%b addr=%h we=%b wdata=%h wreg=%b stall=%0d req_at_done=%b, want 1 %h %b %h %b %0d 0",
                           o_done, o_addr, o_we, o_wdata, o_wreg, o_stall, o_req_at_done, e.addr, e.we, e.wdata, e.wreg, e.stall);
      end
    end
    run_mem(EXE_SW_OP, 32'h404, 32'h0BAD_F00D, 32'h0, 1);
    begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (!o_done || {o_addr, o_bwdata, o_we, o_wreg, o_stall} !== {e.addr, e.bwdata, e.we, e.wreg, e.stall}) begin
        errors++; $display("FAIL b2b_sw: got done=%b addr=%h wdata=%h we=%b wreg=%b stall=%0d, want 1 %h %h %b %b %0d",
                           o_done, o_addr, o_bwdata, o_we, o_wreg, o_stall, e.addr, e.bwdata, e.we, e.wreg, e.stall);
      end
      checks++;
      if (o_first_req != 1 || o_req != 1 || first_addr === o_addr) begin
        errors++; $display("FAIL b2b_separate: got first_req=%0d req_cycles=%0d addrs %h/%h, want 1 1 distinct",
                           o_first_req, o_req, first_addr, o_addr);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    aluOp_i = EXE_LW_OP; wdata_i = 32'h500; wd_i = 5'd9; wreg_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b1 || stallReq !== 1'b1) begin
      errors++; $display("FAIL rst_busy_entry: got req=%b stall=%b, want 1 1", bus_req_o, stallReq);
    end
    rst = 1'b1; aluOp_i = EXE_NOP_OP; wreg_i = 1'b0;
    #1;
    checks++;
    if ({wd_o, wreg_o, wdata_o, stallReq} !== 39'd0) begin
      errors++; $display("FAIL rst_busy_outputs: got wd=%0d wreg=%b wdata=%h stall=%b, want all 0", wd_o, wreg_o, wdata_o, stallReq);
    end
    @(negedge clk);
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
    #1;
    checks++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, stallReq} !== 39'd0) begin
      errors++; $display("FAIL rst_busy_bus: got req=%b we=%b sel=%b addr=%h stall=%b, want all 0",
                         bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, stallReq);
    end
    @(negedge clk);
    bus_ack_i = 1'b0; aluOp_i = EXE_ADD_OP; wdata_i = 32'h0000_0077; wreg_i = 1'b1;
    #1;
    checks++;
    if ({bus_req_o, stallReq, wdata_o, wreg_o} !== {1'b0, 1'b0, 32'h0000_0077, 1'b1}) begin
      errors++; $display("FAIL rst_busy_ack_dropped: got req=%b stall=%b wdata=%h wreg=%b, want 0 0 00000077 1",
                         bus_req_o, stallReq, wdata_o, wreg_o);
    end
    @(posedge clk); #1;
    aluOp_i = EXE_NOP_OP; wreg_i = 1'b0;
  endtask

  task automatic test_align;
`ifdef MEM_ALIGN_CHECK_EN
    logic [7:0]  ops[2]   = '{EXE_LW_OP, EXE_LH_OP};
    logic [31:0] addrs[2] = '{32'h301, 32'h103};
    for (int i = 0; i < 2; i++) begin
      aluOp_i = ops[i]; wdata_i = addrs[i]; wreg_i = 1'b1; wd_i = 5'd5;
      @(negedge clk);
      checks++;
      if ({alignErr_o, bus_req_o, wreg_o, stallReq} !== 4'b1000) begin
        errors++; $display("FAIL align%0d_pulse: got aerr=%b req=%b wreg=%b stall=%b, want 1 0 0 0",
                           i, alignErr_o, bus_req_o, wreg_o, stallReq);
      end
      @(posedge clk); #1;
      aluOp_i = EXE_NOP_OP; wreg_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({alignErr_o, bus_req_o, stallReq} !== 3'b000) begin
        errors++; $display("FAIL align%0d_after: got aerr=%b req=%b stall=%b, want 0 0 0", i, alignErr_o, bus_req_o, stallReq);
      end
      @(posedge clk); #1;
    end
`else
    exp_q.push_back('{addr: 32'h300, sel: 4'b1111, bwdata: 32'h0, we: 1'b0, wdata: 32'h0102_0304, wreg: 1'b1, stall: 2});
    exp_q.push_back('{addr: 32'h200, sel: 4'b0011, bwdata: 32'h0, we: 1'b0, wdata: 32'hFFFF_8BCD, wreg: 1'b1, stall: 2});
    run_mem(EXE_LW_OP, 32'h301, 32'h0, 32'h0102_0304, 1);
    begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (!o_done || o_align || {o_addr, o_sel, o_wdata, o_wreg, o_stall} !== {e.addr, e.sel, e.wdata, e.wreg, e.stall}) begin
        errors++; $display("FAIL unaligned_lw: got done=%b aerr=%b addr=%h sel=%b wdata=%h wreg=%b stall=%0d, want 1 0 %h %b %h %b %0d",
                           o_done, o_align, o_addr, o_sel, o_wdata, o_wreg, o_stall, e.addr, e.sel, e.wdata, e.wreg, e.stall);
      end
    end
    run_mem(EXE_LH_OP, 32'h203, 32'h0, 32'hAAAA_8BCD, 1);
    begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (!o_done || o_align || {o_addr, o_sel, o_wdata, o_wreg, o_stall} !== {e.addr, e.sel, e.wdata, e.wreg, e.stall}) begin
        errors++; $display("FAIL unaligned_lh: got done=%b aerr=%b addr=%h sel=%b wdata=%h wreg=%b stall=%0d, want 1 0 %h %b %h %b %0d",
                           o_done, o_align, o_addr, o_sel, o_wdata, o_wreg, o_stall, e.addr, e.sel, e.wdata, e.wreg, e.stall);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_busy();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage (via the EX/MEM latch) and upstream of the MEM/WB latch. Passes ALU results through unchanged for non-memory ops. For loads and stores it runs a request/acknowledge transaction on the data bus, holds the pipeline with `stallReq` until the access completes, and then delivers byte-lane-aligned, sign- or zero-extended load data. The pipeline is big-endian: byte address offset 0 maps to bits 31:24.

## Interface
- No parameters. Widths come from the shared defines: `RegBus`, `RegAddrBus`, `AluOpBus`.
- `clk` in 1: single pipeline clock.
- `rst` in 1: reset, synchronous, active-high.
- `aluOp_i` in `AluOpBus`: operation code. Memory ops are `EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP`, `EXE_SW_OP`.
- `wd_i` in `RegAddrBus`: destination register.
- `wreg_i` in 1: write-enable from execute.
- `wdata_i` in `RegBus`: ALU result. This is the effective address for memory ops.
- `storeData_i` in `RegBus`: rt value to store.
- `wd_o` out `RegAddrBus`: destination register to MEM/WB.
- `wreg_o` out 1: write-enable to MEM/WB.
- `wdata_o` out `RegBus`: result to MEM/WB.
- `stallReq` out 1: pipeline hold request to the stall controller.
- `bus_addr_o` out 32: word-aligned address (bits 1:0 = 0).
- `bus_wdata_o` out 32: store data, replicated onto all lanes.
- `bus_sel_o` out 4: byte-lane enables. Bit 3 selects bits 31:24.
- `bus_we_o` out 1: 1 = write.
- `bus_req_o` out 1: request. Held high until ack.
- `bus_ack_i` in 1: single-cycle completion.
- `bus_rdata_i` in 32: read data, valid together with ack.
- `alignErr_o` out 1: misaligned access pulse. Tied to 0 unless `MEM_ALIGN_CHECK_EN` is defined.

## Operation
- FSM states: IDLE, BUSY, DONE. All bus outputs are registered.
- **IDLE, non-memory op:**
  - `wd_o` = `wd_i`, `wreg_o` = `wreg_i`, `wdata_o` = `wdata_i` (combinational pass-through).
  - `stallReq` = 0.
- **IDLE, memory op:**
  - `stallReq` = 1; `wreg_o` = WriteDisable; `wdata_o` = `ZeroWord`.
  - Register the address, select lanes, lane data, write flag, op code and `wd`.
  - Set `bus_req_o`; go to BUSY.
- **BUSY:**
  - `stallReq` = 1; `wreg_o` = WriteDisable.
  - Bus outputs stay stable until `bus_ack_i`.
  - On ack:
    - Drop `bus_req_o` at the next edge.
    - Capture the extracted load result in a register.
    - Go to DONE.
- **DONE:**
  - `stallReq` = 0; `wd_o` = latched `wd`.
  - Loads: `wreg_o` = latched `wreg_i`, `wdata_o` = captured result.
  - Stores: `wreg_o` = WriteDisable, `wdata_o` = `ZeroWord`.
  - The pipeline advances at the end of this cycle; unconditional return to IDLE.
- **Lane selection by address bits 1:0:**
  - Byte: offset 00→`1000`, 01→`0100`, 10→`0010`, 11→`0001`.
  - Half: offset 00→`1100`, 10→`0011`.
  - Word: `1111`.
- **Store data:** SB replicates `storeData_i[7:0]` ×4; SH replicates `storeData_i[15:0]` ×2; SW passes it through.
- **Load extraction:** pick the selected lane.
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend to 32 bits.
  - LW takes the whole word.
- **Boundary conditions:**
  - `bus_ack_i` in IDLE or DONE is ignored.
  - Ack in the same cycle the request is first seen is impossible, because the request is registered.
  - Back-to-back memory ops each take their own IDLE→BUSY→DONE sequence.
- **Reset** (any state, including mid-BUSY):
  - Next edge: IDLE, `bus_req_o`/`bus_we_o` = 0, `bus_sel_o` = 0, `bus_addr_o` = 0, `bus_wdata_o` = 0, captured data = 0, `alignErr_o` = 0.
  - While `rst` is high, `wd_o` = 0, `wreg_o` = 0, `wdata_o` = 0, `stallReq` = 0.
  - A pending ack after reset is dropped.

## Timing
- Non-memory op: 0 cycles.
- Memory op entering at cycle 0, ack at cycle k (k ≥ 1):
  - `bus_req_o` is high from cycle 1 through cycle k.
  - DONE is cycle k+1.
  - Stall length is k+1 cycles; total occupancy is k+2 cycles.
- No timeout: a missing ack stalls indefinitely.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access is a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0.
  - It issues no bus request; `alignErr_o` pulses for one cycle (the cycle it is seen in IDLE).
  - `wreg_o` = WriteDisable, `stallReq` = 0, state stays IDLE.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Low address bits beyond the access size are ignored: halfword uses addr[1] only, word uses neither.
  - The access proceeds normally; `alignErr_o` = 0.

## Structure
- Shared defines file: the memory `EXE_*_OP` codes, `RegBus`, `ZeroWord`, `WriteDisable`, and the FSM state encodings.
- One sub-module, `mem_lane_ext`: combinational lane extraction and sign/zero extension (`rdata`, offset, op → result).

## Test plan
- ADD result 0x0000_1234, `wreg_i` = 1 → same cycle: `wdata_o` = 0x0000_1234, `wreg_o` = 1, `stallReq` = 0, `bus_req_o` = 0.
- LB at addr 0x103, `bus_rdata_i` = 0x1122_3380, ack 2 cycles after `bus_req_o` rises:
  - Bus: `bus_sel_o` = `0001`, `bus_addr_o` = 0x100.
  - `stallReq` high for 3 cycles.
  - DONE: `wdata_o` = 0xFFFF_FF80. The LBU variant gives 0x0000_0080.
- SH at addr 0x202, `storeData_i` = 0xDEAD_BEEF → `bus_sel_o` = `0011`, `bus_wdata_o` = 0xBEEF_BEEF, `bus_we_o` = 1. DONE: `wreg_o` = 0.
- LW then SW back-to-back, each with 1-cycle ack → two distinct requests, the second issued only after the first reaches DONE.
- `rst` asserted mid-BUSY with ack the following cycle → `bus_req_o` = 0 after the edge, state IDLE, ack ignored, no write-back.
- With `MEM_ALIGN_CHECK_EN`, LW at 0x301 → `alignErr_o` = 1 for one cycle, `bus_req_o` stays 0, `wreg_o` = 0.
